ft600_bus_scheduler: RTL

Half-duplex bus scheduler for the FT600 245-synchronous interface, placed between the FT600 PHY (pin-level send/receive block) and the FPGA-side producers and consumer. Grants the shared 16-bit bus to either the read direction (host→FPGA) or the write direction (FPGA→host), inserts turnaround idle cycles on direction change, and bounds every grant to a burst length. Arbitrates two TX sources round-robin at packet boundaries, and buffers RX words in a small skid FIFO so that words still in flight after a read grant ends are never lost.

---
 rtl/ft600_bus_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ft600_bus_scheduler.sv
// ft600_bus_scheduler: half-duplex FT600 bus arbiter with turnaround, burst limits,
// round-robin TX source selection and an RX skid FIFO that absorbs in-flight words.
module ft600_bus_scheduler #(
  parameter int BURST_MAX   = 256,
  parameter int TURN_CYCLES = 2,
  parameter int RX_DEPTH    = 8,
  parameter int RX_MARGIN   = 3,
  parameter int WR_IDLE_MAX = 4
) (
  input  logic        ftdi_clk,
  input  logic        rst_n,
  input  logic        phy_rx_avail,
  input  logic        phy_tx_space,
  input  logic        phy_rx_valid,
  input  logic [15:0] phy_rx_data,
  input  logic [1:0]  phy_rx_be,
  input  logic        phy_tx_ready,
  output logic        phy_rd_grant,
  output logic        phy_wr_grant,
  output logic        phy_tx_valid,
  output logic [15:0] phy_tx_data,
  output logic [1:0]  phy_tx_be,
  input  logic        src0_valid,
  input  logic [15:0] src0_data,
  input  logic [1:0]  src0_be,
  input  logic        src0_last,
  output logic        src0_ready,
  input  logic        src1_valid,
  input  logic [15:0] src1_data,
  input  logic [1:0]  src1_be,
  input  logic        src1_last,
  output logic        src1_ready,
  output logic        sink_valid,
  output logic [15:0] sink_data,
  output logic [1:0]  sink_be,
  input  logic        sink_ready,
  output logic        active_src,
  output logic        rx_overflow
);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int TW = $clog2(TURN_CYCLES + 1);
  localparam int IW = $clog2(WR_IDLE_MAX + 1);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = $clog2(RX_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, TURN, READ, WRITE} state_t;

  state_t        state_q;
  logic          last_wr_q, dir_rd_q, rr_q, active_src_q, rd_grant_q, wr_grant_q, overflow_q;
  logic [BW-1:0] burst_q;
  logic [TW-1:0] turn_q;
  logic [IW-1:0] idle_q;
  logic [15:0]   mem_data [RX_DEPTH];
  logic [1:0]    mem_be [RX_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d, free;
  logic          rd_req, wr_req, pick_rd, sel_valid, sel_last, tx_acc, first_src, burst_hit;
  logic          rd_exit, wr_exit, enter, enter_rd, push, pop, full, wr_en;

  always_comb begin
    free      = CW'(RX_DEPTH) - count_q;
    rd_req    = phy_rx_avail & (free > CW'(RX_MARGIN));
    wr_req    = phy_tx_space & (src0_valid | src1_valid);
    pick_rd   = rd_req & (!wr_req | last_wr_q);
    sel_valid = active_src_q ? src1_valid : src0_valid;
    sel_last  = active_src_q ? src1_last : src0_last;
    tx_acc    = phy_tx_valid & phy_tx_ready;
    first_src = (rr_q ? src1_valid : src0_valid) ? rr_q : ~rr_q;
    burst_hit = (burst_q + BW'(1)) == BW'(BURST_MAX);
    rd_exit   = (phy_rx_valid & burst_hit) | !phy_rx_avail | (free <= CW'(RX_MARGIN));
    wr_exit   = (tx_acc & (burst_hit | sel_last)) | !phy_tx_space |
                (!sel_valid & ((idle_q + IW'(1)) == IW'(WR_IDLE_MAX)));
    // a grant starts straight from IDLE when the direction is unchanged, else after TURN
    enter     = (state_q == IDLE & (rd_req | wr_req) & (pick_rd != last_wr_q)) |
                (state_q == TURN & turn_q == '0 & (dir_rd_q ? rd_req : wr_req));
    enter_rd  = (state_q == IDLE) ? pick_rd : dir_rd_q;
  end

  always_ff @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_wr_q    <= 1'b1;
      dir_rd_q     <= 1'b0;
      rr_q         <= 1'b0;
      active_src_q <= 1'b0;
      rd_grant_q   <= 1'b0;
      wr_grant_q   <= 1'b0;
      burst_q      <= '0;
      turn_q       <= '0;
      idle_q       <= '0;
    end else if (enter) begin
      state_q    <= enter_rd ? READ : WRITE;
      rd_grant_q <= enter_rd;
      wr_grant_q <= !enter_rd;
      burst_q    <= '0;
      idle_q     <= '0;
      if (!enter_rd) active_src_q <= first_src;
    end else begin
      case (state_q)
        IDLE: if (rd_req | wr_req) begin
          state_q  <= TURN;
          dir_rd_q <= pick_rd;
          turn_q   <= TW'(TURN_CYCLES - 1);
        end
        TURN: if (turn_q == '0) state_q <= IDLE;
              else turn_q <= turn_q - TW'(1);
        READ: if (rd_exit) begin
          state_q    <= IDLE;
          rd_grant_q <= 1'b0;
          last_wr_q  <= 1'b0;
        end else if (phy_rx_valid) burst_q <= burst_q + BW'(1);
        WRITE: if (wr_exit) begin
          state_q    <= IDLE;
          wr_grant_q <= 1'b0;
          last_wr_q  <= 1'b1;
          rr_q       <= ~active_src_q;
        end else begin
          if (tx_acc) burst_q <= burst_q + BW'(1);
          idle_q <= sel_valid ? '0 : idle_q + IW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign phy_rd_grant = rd_grant_q;
  assign phy_wr_grant = wr_grant_q;
  assign active_src   = active_src_q;
  assign phy_tx_valid = wr_grant_q & sel_valid;
  assign phy_tx_data  = wr_grant_q ? (active_src_q ? src1_data : src0_data) : '0;
  assign phy_tx_be    = wr_grant_q ? (active_src_q ? src1_be : src0_be) : '0;
  assign src0_ready   = wr_grant_q & !active_src_q & phy_tx_ready;
  assign src1_ready   = wr_grant_q & active_src_q & phy_tx_ready;

  // full FIFO still accepts a push when the head is popped in the same cycle
  assign push    = phy_rx_valid;
  assign pop     = sink_valid & sink_ready;
  assign full    = count_q == CW'(RX_DEPTH);
  assign wr_en   = push & (!full | pop);
  assign count_d = count_q + CW'(wr_en) - CW'(pop);

  always_ff @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (push & !wr_en) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge ftdi_clk) begin
    if (wr_en) begin
      mem_data[wr_ptr_q] <= phy_rx_data;
      mem_be[wr_ptr_q]   <= phy_rx_be;
    end
  end

  assign sink_valid  = count_q != '0;
  assign sink_data   = mem_data[rd_ptr_q];
  assign sink_be     = mem_be[rd_ptr_q];
  assign rx_overflow = overflow_q;
endmodule
